// File: rtl/lm96570_cfg_seq.sv
// rtl/lm96570_cfg_seq.sv - configuration table sequencer for the LM96570 SPI engine
//
// Walks a table of SPI shift words held in a synchronous ROM (1-cycle read
// latency) and issues one engine transaction per entry. Each transaction is
// followed by a chip-select-high gap and guarded by a watchdog.
//
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   CFG_START           1-cycle pulse, begins a sequence when idle
//   CFG_ABORT           level, abort at the next state boundary
//   NUM_ENTRIES         entry count, latched on an accepted start
//   CFG_BUSY            high from accepted start until the cycle after CFG_DONE
//   CFG_DONE            1-cycle end-of-sequence pulse
//   CFG_ERR, ERR_IDX    0 ok / 1 timeout / 2 bad bit count / 3 aborted, and entry index
//   TBL_ADDR            ROM address
//   TBL_DATA, TBL_NBIT  ROM word and its bit count
//   SPI_START           engine START
//   SPI_DONE            engine DONE
//   SPI_DATA_IN         engine DATA_IN, held for the whole transaction
//   SPI_NUM_OF_BIT      engine NUM_OF_BIT, held for the whole transaction
//   SPI_RD_DATA         engine RD_DATA
//   LAST_RD_DATA        SPI_RD_DATA captured on each accepted SPI_DONE

module lm96570_cfg_seq #(
  parameter int DATA_WIDTH      = 70,
  parameter int BIT_COUNT_WIDTH = 8,
  parameter int ADDR_WIDTH      = 4,
  parameter int GAP_CYCLES      = 16,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       CFG_START,
  input  logic                       CFG_ABORT,
  input  logic [ADDR_WIDTH:0]        NUM_ENTRIES,
  output logic                       CFG_BUSY,
  output logic                       CFG_DONE,
  output logic [1:0]                 CFG_ERR,
  output logic [ADDR_WIDTH-1:0]      ERR_IDX,
  output logic [ADDR_WIDTH-1:0]      TBL_ADDR,
  input  logic [DATA_WIDTH-1:0]      TBL_DATA,
  input  logic [BIT_COUNT_WIDTH-1:0] TBL_NBIT,
  output logic                       SPI_START,
  input  logic                       SPI_DONE,
  output logic [DATA_WIDTH-1:0]      SPI_DATA_IN,
  output logic [BIT_COUNT_WIDTH-1:0] SPI_NUM_OF_BIT,
  input  logic [DATA_WIDTH-1:0]      SPI_RD_DATA,
  output logic [DATA_WIDTH-1:0]      LAST_RD_DATA
);

  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  localparam logic [ADDR_WIDTH:0] MAX_ENTRIES = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_ENTRY   = (ADDR_WIDTH + 1)'(1);
  localparam logic [WDOG_W-1:0]   WDOG_LAST   = WDOG_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(GAP_CYCLES - 1);

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_NBIT    = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LAUNCH,
    ST_WAIT,
    ST_GAP,
    ST_FINISH
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDR_WIDTH-1:0]      idx_q, idx_d;
  logic [ADDR_WIDTH:0]        num_q, num_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic [1:0]                 err_q, err_d;
  logic [ADDR_WIDTH-1:0]      err_idx_q, err_idx_d;
  logic                       start_q, start_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic [BIT_COUNT_WIDTH-1:0] nbit_q, nbit_d;
  logic [DATA_WIDTH-1:0]      rd_q, rd_d;
  logic [WDOG_W-1:0]          wdog_q, wdog_d;
  logic [GAP_W-1:0]           gap_q, gap_d;

  logic advance;
  logic last_entry;
  logic nbit_too_big;

  assign last_entry   = ({1'b0, idx_q} == (num_q - ONE_ENTRY));
  assign nbit_too_big = 32'(TBL_NBIT) > 32'(DATA_WIDTH);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    num_d     = num_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    start_d   = 1'b0;
    data_d    = data_q;
    nbit_d    = nbit_q;
    rd_d      = rd_q;
    wdog_d    = wdog_q;
    gap_d     = gap_q;
    advance   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Busy drops in the cycle after the done pulse; a start seen while
        // busy is still high is ignored.
        if (done_q) begin
          busy_d = 1'b0;
        end
        if (CFG_START && !busy_q) begin
          num_d     = (NUM_ENTRIES > MAX_ENTRIES) ? MAX_ENTRIES : NUM_ENTRIES;
          err_d     = ERR_OK;
          err_idx_d = '0;
          idx_d     = '0;
          busy_d    = 1'b1;
          state_d   = (NUM_ENTRIES == '0) ? ST_FINISH : ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (CFG_ABORT) begin
          err_d     = ERR_ABORT;
          err_idx_d = idx_q;
          state_d   = ST_FINISH;
        end else begin
          state_d = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        if (CFG_ABORT) begin
          err_d     = ERR_ABORT;
          err_idx_d = idx_q;
          state_d   = ST_FINISH;
        end else if (TBL_NBIT == '0) begin
          advance = 1'b1;
        end else if (nbit_too_big) begin
          err_d     = ERR_NBIT;
          err_idx_d = idx_q;
          state_d   = ST_FINISH;
        end else begin
          data_d  = TBL_DATA;
          nbit_d  = TBL_NBIT;
          start_d = 1'b1;
          wdog_d  = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Abort is deliberately not looked at here so a frame is never cut;
        // it is picked up in the following gap. A DONE overlapping our own
        // START cycle belongs to nothing we issued.
        if (SPI_DONE && !start_q) begin
          rd_d    = SPI_RD_DATA;
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (wdog_q == WDOG_LAST) begin
          err_d     = ERR_TIMEOUT;
          err_idx_d = idx_q;
          state_d   = ST_FINISH;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (CFG_ABORT) begin
          err_d     = ERR_ABORT;
          err_idx_d = idx_q;
          state_d   = ST_FINISH;
        end else if (gap_q == GAP_LAST) begin
          advance = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      ST_FINISH: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (advance) begin
      if (last_entry) begin
        state_d = ST_FINISH;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_FETCH;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      num_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= ERR_OK;
      err_idx_q <= '0;
      start_q   <= 1'b0;
      data_q    <= '0;
      nbit_q    <= '0;
      rd_q      <= '0;
      wdog_q    <= '0;
      gap_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      num_q     <= num_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      start_q   <= start_d;
      data_q    <= data_d;
      nbit_q    <= nbit_d;
      rd_q      <= rd_d;
      wdog_q    <= wdog_d;
      gap_q     <= gap_d;
    end
  end

  assign CFG_BUSY       = busy_q;
  assign CFG_DONE       = done_q;
  assign CFG_ERR        = err_q;
  assign ERR_IDX        = err_idx_q;
  assign TBL_ADDR       = idx_q;
  assign SPI_START      = start_q;
  assign SPI_DATA_IN    = data_q;
  assign SPI_NUM_OF_BIT = nbit_q;
  assign LAST_RD_DATA   = rd_q;

endmodule

// File: tb/tb_lm96570_cfg_seq.sv
// tb/tb_lm96570_cfg_seq.sv - self-checking bench for lm96570_cfg_seq

module tb_lm96570_cfg_seq;

  localparam int DW  = 70;
  localparam int BW  = 8;
  localparam int AW  = 4;
  localparam int GAP = 16;
  localparam int TMO = 300;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          CFG_START = 1'b0;
  logic          CFG_ABORT = 1'b0;
  logic [AW:0]   NUM_ENTRIES = '0;
  logic          CFG_BUSY;
  logic          CFG_DONE;
  logic [1:0]    CFG_ERR;
  logic [AW-1:0] ERR_IDX;
  logic [AW-1:0] TBL_ADDR;
  logic [DW-1:0] TBL_DATA = '0;
  logic [BW-1:0] TBL_NBIT = '0;
  logic          SPI_START;
  logic          SPI_DONE = 1'b0;
  logic [DW-1:0] SPI_DATA_IN;
  logic [BW-1:0] SPI_NUM_OF_BIT;
  logic [DW-1:0] SPI_RD_DATA = '0;
  logic [DW-1:0] LAST_RD_DATA;

  always #5 CLK = ~CLK;

  lm96570_cfg_seq #(
    .DATA_WIDTH(DW), .BIT_COUNT_WIDTH(BW), .ADDR_WIDTH(AW),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CFG_START(CFG_START), .CFG_ABORT(CFG_ABORT),
    .NUM_ENTRIES(NUM_ENTRIES), .CFG_BUSY(CFG_BUSY), .CFG_DONE(CFG_DONE),
    .CFG_ERR(CFG_ERR), .ERR_IDX(ERR_IDX), .TBL_ADDR(TBL_ADDR),
    .TBL_DATA(TBL_DATA), .TBL_NBIT(TBL_NBIT), .SPI_START(SPI_START),
    .SPI_DONE(SPI_DONE), .SPI_DATA_IN(SPI_DATA_IN),
    .SPI_NUM_OF_BIT(SPI_NUM_OF_BIT), .SPI_RD_DATA(SPI_RD_DATA),
    .LAST_RD_DATA(LAST_RD_DATA)
  );

  // synchronous ROM, one cycle read latency
  logic [DW-1:0] rom_data [16];
  logic [BW-1:0] rom_nbit [16];
  always @(posedge CLK) begin
    TBL_DATA <= rom_data[TBL_ADDR];
    TBL_NBIT <= rom_nbit[TBL_ADDR];
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [BW-1:0] nbit;
    int            cyc;
  } start_t;

  start_t        starts[$];
  start_t        exp_starts[$];
  int            dones[$];
  int            hang_ord = -1;
  int            start_ord = 0;
  int            eng_cnt = 0;
  logic [DW-1:0] exp_last_rd = '0;
  logic [95:0]   rnd96;
  int            checks = 0;
  int            errors = 0;

  // Engine model: DONE comes 20 cycles after the START cycle has passed,
  // except on the start ordinal marked as hung. Also logs START/DONE activity.
  always @(negedge CLK) begin
    if (CFG_DONE) dones.push_back(cyc);
    if (RESET) begin
      eng_cnt  = 0;
      SPI_DONE = 1'b0;
    end else begin
      SPI_DONE = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt = eng_cnt - 1;
        if (eng_cnt == 0) begin
          rnd96       = {$urandom(), $urandom(), $urandom()};
          SPI_RD_DATA = rnd96[DW-1:0];
          exp_last_rd = rnd96[DW-1:0];
          SPI_DONE    = 1'b1;
        end
      end
      if (SPI_START) begin
        starts.push_back('{SPI_DATA_IN, SPI_NUM_OF_BIT, cyc});
        if (start_ord != hang_ord) eng_cnt = 21;
        start_ord = start_ord + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp_v);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp_v);
    end
  endtask

  // Reference: walk the table by the sequencing rules and predict every
  // START (contents and cycle), the final status and the CFG_DONE cycle.
  // c0 is the cycle in which CFG_START is high.
  task automatic model(input int num, input int hang, input bit abort, input int c0,
                       output int e_err, output int e_idx, output int e_done);
    int n;
    int t;
    int ord;
    n = (num > 16) ? 16 : num;
    t = c0 + 3;
    ord = 0;
    exp_starts.delete();
    e_err = 0;
    e_idx = 0;
    for (int i = 0; i < n; i++) begin
      if (rom_nbit[i] == 0) begin
        t += 2;
        continue;
      end
      if (int'(rom_nbit[i]) > DW) begin
        e_err = 2; e_idx = i; e_done = t + 1;
        return;
      end
      exp_starts.push_back('{rom_data[i], rom_nbit[i], t});
      if (ord == hang) begin
        e_err = 1; e_idx = i; e_done = t + TMO + 1;
        return;
      end
      if (abort) begin
        e_err = 3; e_idx = i; e_done = t + 24;
        return;
      end
      ord++;
      t += 1 + 20 + GAP + 3;
    end
    e_done = t - 1;
  endtask

  task automatic run_seq(input string nm, input int num, input int hang, input bit abort,
                         input bit use_model, input int t_err, input int t_idx, input int t_n);
    int c0, e_err, e_idx, e_done, n_exp, extra, n_cmp;
    bit got, abort_on;
    starts.delete();
    dones.delete();
    hang_ord  = hang;
    start_ord = 0;
    @(negedge CLK);
    CFG_START   = 1'b1;
    NUM_ENTRIES = (AW + 1)'(num);
    c0 = cyc;
    model(num, hang, abort, c0, e_err, e_idx, e_done);
    n_exp = exp_starts.size();
    if (!use_model) begin
      e_err = t_err;
      e_idx = t_idx;
      n_exp = t_n;
    end
    @(negedge CLK);
    CFG_START   = 1'b0;
    NUM_ENTRIES = (AW + 1)'($urandom());
    got = 0;
    abort_on = 0;
    extra = 0;
    for (int k = 0; k < 3000 && extra < 3; k++) begin
      @(negedge CLK);
      #1;
      CFG_START = 1'b0;
      if (abort && !abort_on && starts.size() > 0) begin
        CFG_ABORT   = 1'b1;
        CFG_START   = 1'b1;
        NUM_ENTRIES = (AW + 1)'(2);
        abort_on    = 1;
      end
      if (got) begin
        if (extra == 0) chk_int({nm, " busy_after_done"}, int'(CFG_BUSY), 0);
        extra++;
      end else if (dones.size() > 0) begin
        got = 1;
        chk_int({nm, " err"}, int'(CFG_ERR), e_err);
        chk_int({nm, " err_idx"}, int'(ERR_IDX), e_idx);
        chk_int({nm, " busy_at_done"}, int'(CFG_BUSY), 1);
        CFG_ABORT = 1'b0;
      end
    end
    CFG_ABORT = 1'b0;
    CFG_START = 1'b0;
    chk_int({nm, " done_count"}, dones.size(), 1);
    if (got) chk_int({nm, " done_cycle"}, dones[0] - c0, e_done - c0);
    chk_int({nm, " start_count"}, starts.size(), n_exp);
    n_cmp = (starts.size() < exp_starts.size()) ? starts.size() : exp_starts.size();
    for (int i = 0; i < n_cmp; i++) begin
      chk($sformatf("%s start%0d data", nm, i), starts[i].data, exp_starts[i].data);
      chk_int($sformatf("%s start%0d nbit", nm, i), int'(starts[i].nbit), int'(exp_starts[i].nbit));
      chk_int($sformatf("%s start%0d cycle", nm, i), starts[i].cyc - c0, exp_starts[i].cyc - c0);
    end
    chk({nm, " last_rd"}, LAST_RD_DATA, exp_last_rd);
  endtask

  task automatic load_set(input int s);
    for (int i = 0; i < 16; i++) begin
      rnd96 = {$urandom(), $urandom(), $urandom()};
      rom_data[i] = rnd96[DW-1:0];
      rom_nbit[i] = BW'($urandom_range(1, DW));
    end
    case (s)
      0: begin
        rom_data[0] = DW'(32'h1A);  rom_nbit[0] = 8'd5;
        rom_data[1] = DW'(32'h3FF); rom_nbit[1] = 8'd10;
        rom_data[2] = '1;           rom_nbit[2] = 8'd70;
      end
      1: begin
        rom_data[0] = DW'(32'h11); rom_nbit[0] = 8'd8;
        rom_data[1] = DW'(32'h22); rom_nbit[1] = 8'd0;
        rom_data[2] = DW'(32'h33); rom_nbit[2] = 8'd71;
        rom_data[3] = DW'(32'h44); rom_nbit[3] = 8'd4;
      end
      2: begin
        rom_data[0] = DW'(32'h5);   rom_nbit[0] = 8'd0;
        rom_data[1] = DW'(32'hABC); rom_nbit[1] = 8'd12;
        rom_data[2] = DW'(32'h123); rom_nbit[2] = 8'd70;
      end
      default: begin
        for (int i = 0; i < 16; i++) begin
          rom_data[i] = DW'(i * 32'h1111 + 1);
          rom_nbit[i] = BW'(i + 1);
        end
      end
    endcase
  endtask

  typedef struct {
    int num;
    int rom_set;
    int hang;
    bit abort;
    int exp_err;
    int exp_idx;
    int exp_n;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #900000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3,  0, -1, 1'b0, 0, 0, 3};
    vecs[1] = '{0,  0, -1, 1'b0, 0, 0, 0};
    vecs[2] = '{3,  0,  1, 1'b0, 1, 1, 2};
    vecs[3] = '{4,  1, -1, 1'b0, 2, 2, 1};
    vecs[4] = '{3,  0, -1, 1'b1, 3, 0, 1};
    vecs[5] = '{3,  2, -1, 1'b0, 0, 0, 2};
    vecs[6] = '{20, 3, -1, 1'b0, 0, 0, 16};

    load_set(0);
    repeat (3) @(negedge CLK);
    #1;
    chk_int("reset busy", int'(CFG_BUSY), 0);
    chk_int("reset done", int'(CFG_DONE), 0);
    chk_int("reset err", int'(CFG_ERR), 0);
    chk_int("reset spi_start", int'(SPI_START), 0);
    chk_int("reset tbl_addr", int'(TBL_ADDR), 0);
    chk("reset last_rd", LAST_RD_DATA, '0);
    @(negedge CLK);
    RESET = 1'b0;

    for (int v = 0; v < 7; v++) begin
      load_set(vecs[v].rom_set);
      run_seq($sformatf("vec%0d", v), vecs[v].num, vecs[v].hang, vecs[v].abort,
              1'b0, vecs[v].exp_err, vecs[v].exp_idx, vecs[v].exp_n);
    end

    // asynchronous reset in the middle of a transaction
    load_set(0);
    starts.delete();
    dones.delete();
    hang_ord  = -1;
    start_ord = 0;
    @(negedge CLK);
    CFG_START   = 1'b1;
    NUM_ENTRIES = (AW + 1)'(3);
    @(negedge CLK);
    CFG_START = 1'b0;
    for (int k = 0; k < 100 && starts.size() == 0; k++) begin
      @(negedge CLK);
      #1;
    end
    chk_int("rst_mid first_start", starts.size(), 1);
    repeat (5) @(negedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    chk_int("rst_mid busy", int'(CFG_BUSY), 0);
    chk_int("rst_mid done", int'(CFG_DONE), 0);
    chk_int("rst_mid err", int'(CFG_ERR), 0);
    chk_int("rst_mid err_idx", int'(ERR_IDX), 0);
    chk_int("rst_mid spi_start", int'(SPI_START), 0);
    chk_int("rst_mid spi_nbit", int'(SPI_NUM_OF_BIT), 0);
    chk("rst_mid spi_data", SPI_DATA_IN, '0);
    chk("rst_mid last_rd", LAST_RD_DATA, '0);
    exp_last_rd = '0;
    repeat (4) @(negedge CLK);
    RESET = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    chk_int("rst_mid no_done", dones.size(), 0);
    chk_int("rst_mid idle_busy", int'(CFG_BUSY), 0);
    run_seq("post_reset", 3, -1, 1'b0, 1'b0, 0, 0, 3);

    // randomized tables against the reference
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 16; i++) begin
        int sel;
        rnd96 = {$urandom(), $urandom(), $urandom()};
        rom_data[i] = rnd96[DW-1:0];
        sel = $urandom_range(0, 19);
        if (sel == 0)      rom_nbit[i] = 8'd0;
        else if (sel == 1) rom_nbit[i] = BW'($urandom_range(71, 255));
        else               rom_nbit[i] = BW'($urandom_range(1, DW));
      end
      run_seq($sformatf("rnd%0d", r), $urandom_range(0, 20),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : -1,
              1'b0, 1'b1, 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
